// File: rtl/alarm_pkg.sv
// Shared types, time constants and wrap-around snooze arithmetic for the
// multi-channel alarm engine.
package alarm_pkg;

  localparam int HOURS = 24;
  localparam int MINS  = 60;
  localparam int HW    = 5;
  localparam int MW    = 6;

  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} state_e;
  typedef enum logic       {CMD_ACK, CMD_SNOOZE} cmd_e;

  typedef struct packed {
    logic [HW-1:0] h;
    logic [MW-1:0] m;
  } hm_t;

  typedef struct packed {
    logic we;
    hm_t  t;
    logic en;
  } cfg_t;

  // now + delta minutes, wrapping minute->hour and hour->day
  function automatic hm_t snooze_add(input logic [HW-1:0] h,
                                     input logic [MW-1:0] m,
                                     input int            delta);
    logic [6:0]    mm;
    logic [HW-1:0] hh;
    hm_t           r;
    mm = {1'b0, m} + 7'(delta);
    hh = h;
    if (mm >= 7'(MINS)) begin
      mm = mm - 7'(MINS);
      hh = hh + 5'd1;
    end
    if (hh == 5'(HOURS)) hh = '0;
    r.h = hh;
    r.m = mm[MW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/alarm_chan.sv
// One alarm channel: target/snooze compare, ring FSM, ring timeout and
// snooze bookkeeping.
module alarm_chan
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 2,
  parameter int MAX_SNOOZE = 3
) (
  input  logic mclk,
  input  logic rst,
  input  cfg_t cfg,
  input  logic cmd_v,
  input  cmd_e cmd_op,
  input  hm_t  now,
  input  logic min_tick,
  output logic ringing,
  output logic ring_nxt,
  output logic timeout_p
);

  localparam int SCW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  state_e         state, state_n;
  hm_t            tgt, tgt_n, snz, snz_n;
  logic           en, en_n;
  logic [SCW-1:0] scnt, scnt_n;
  logic [3:0]     rcnt, rcnt_n;
  logic           m, m_d, fire, tmo;
  hm_t            cmp;

  // RINGING/IDLE compare against the main target so a match held across
  // an ACK keeps m_d high and cannot re-fire in the same minute.
  always_comb begin
    cmp  = (state == SNOOZED) ? snz : tgt;
    m    = (now == cmp);
    fire = m && !m_d && (state == ARMED || state == SNOOZED);
    tmo  = (state == RINGING) && min_tick && (rcnt + 4'd1 == 4'(RING_MIN));
  end

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    snz_n   = snz;
    en_n    = en;
    scnt_n  = scnt;
    rcnt_n  = rcnt;
    if (cfg.we) begin
      tgt_n   = cfg.t;
      en_n    = cfg.en;
      scnt_n  = '0;
      state_n = cfg.en ? ARMED : IDLE;
    end else if (tmo) begin
      state_n = en ? ARMED : IDLE;
      scnt_n  = '0;
    end else if (state == RINGING) begin
      if (min_tick) rcnt_n = rcnt + 4'd1;
      if (cmd_v) begin
        if (cmd_op == CMD_SNOOZE && scnt < SCW'(MAX_SNOOZE)) begin
          state_n = SNOOZED;
          scnt_n  = scnt + SCW'(1);
          snz_n   = snooze_add(now.h, now.m, SNOOZE_MIN);
        end else begin
          state_n = ARMED;
          scnt_n  = '0;
        end
      end
    end else if (fire) begin
      state_n = RINGING;
      rcnt_n  = '0;
    end
  end

  assign ringing  = (state == RINGING);
  assign ring_nxt = (state_n == RINGING);

  always_ff @(posedge mclk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      snz       <= '0;
      en        <= 1'b0;
      scnt      <= '0;
      rcnt      <= '0;
      m_d       <= 1'b0;
      timeout_p <= 1'b0;
    end else begin
      state     <= state_n;
      tgt       <= tgt_n;
      snz       <= snz_n;
      en        <= en_n;
      scnt      <= scnt_n;
      rcnt      <= rcnt_n;
      m_d       <= m;
      timeout_p <= tmo && !cfg.we;
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// N_CH-channel alarm engine top: config/command decode, per-channel
// instances, ring summary and lowest-index ringing channel encode.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 2,
  parameter int MAX_SNOOZE = 3,
  localparam int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            mclk,
  input  logic            rst,
  input  logic [HW-1:0]   nowH,
  input  logic [MW-1:0]   nowM,
  input  logic            set_we,
  input  logic [CHW-1:0]  set_ch,
  input  logic [HW-1:0]   set_h,
  input  logic [MW-1:0]   set_m,
  input  logic            set_en,
  input  logic            cmd_valid,
  input  logic            cmd_op,
  input  logic [CHW-1:0]  cmd_ch,
  output logic [N_CH-1:0] ringing,
  output logic            any_ring,
  output logic [CHW-1:0]  ring_ch,
  output logic [N_CH-1:0] timeout_p,
  output logic            set_err
);

  hm_t            now_hm, set_hm;
  logic [MW-1:0]  nowM_q;
  logic           min_tick, set_ok;
  logic [N_CH-1:0] ring_nxt;
  logic [CHW-1:0] enc;

  assign now_hm   = '{h: nowH, m: nowM};
  assign set_hm   = '{h: set_h, m: set_m};
  assign min_tick = (nowM != nowM_q);
  assign set_ok   = (set_h <= 5'(HOURS - 1)) && (set_m <= 6'(MINS - 1)) &&
                    (32'(set_ch) < N_CH);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cfg_t cfg;
    logic cmd_v;
    assign cfg   = '{we: set_we && set_ok && (set_ch == CHW'(i)), t: set_hm, en: set_en};
    assign cmd_v = cmd_valid && (cmd_ch == CHW'(i));

    alarm_chan #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_MIN   (RING_MIN),
      .MAX_SNOOZE (MAX_SNOOZE)
    ) u_chan (
      .mclk      (mclk),
      .rst       (rst),
      .cfg       (cfg),
      .cmd_v     (cmd_v),
      .cmd_op    (cmd_e'(cmd_op)),
      .now       (now_hm),
      .min_tick  (min_tick),
      .ringing   (ringing[i]),
      .ring_nxt  (ring_nxt[i]),
      .timeout_p (timeout_p[i])
    );
  end

  assign any_ring = |ringing;

  // encode from next-state so ring_ch lines up with the registered ringing
  always_comb begin
    enc = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ring_nxt[i]) enc = CHW'(i);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      nowM_q  <= '0;
      ring_ch <= '0;
      set_err <= 1'b0;
    end else begin
      nowM_q  <= nowM;
      ring_ch <= enc;
      set_err <= set_we && !set_ok;
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: fire, ACK, snooze wrap/limit, timeout,
// multi-channel priority, config rejection and reset.
module tb_alarm_bank;

  logic       mclk, rst;
  logic [4:0] nowH, set_h;
  logic [5:0] nowM, set_m;
  logic       set_we, set_en, cmd_valid, cmd_op;
  logic [1:0] set_ch, cmd_ch, ring_ch;
  logic [3:0] ringing, timeout_p;
  logic       any_ring, set_err;

  int n_cmp = 0;
  int n_err = 0;

  alarm_bank #(.N_CH(4), .SNOOZE_MIN(5), .RING_MIN(2), .MAX_SNOOZE(3)) dut (
    .mclk(mclk), .rst(rst), .nowH(nowH), .nowM(nowM),
    .set_we(set_we), .set_ch(set_ch), .set_h(set_h), .set_m(set_m), .set_en(set_en),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ch(cmd_ch),
    .ringing(ringing), .any_ring(any_ring), .ring_ch(ring_ch),
    .timeout_p(timeout_p), .set_err(set_err)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int h, input int m, input int n);
    nowH = 5'(h);
    nowM = 6'(m);
    step(n);
  endtask

  task automatic cfg(input int ch, input int h, input int m, input logic en);
    set_we = 1'b1; set_ch = 2'(ch); set_h = 5'(h); set_m = 6'(m); set_en = en;
    step(1);
    set_we = 1'b0;
  endtask

  task automatic cmd(input int ch, input logic op);
    cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_op = op;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; nowH = 5'd7; nowM = 6'd29;
    set_we = 0; set_ch = 0; set_h = 0; set_m = 0; set_en = 0;
    cmd_valid = 0; cmd_op = 0; cmd_ch = 0;
    step(2);
    chk("rst_ringing", 32'(ringing), 0);
    chk("rst_any", 32'(any_ring), 0);
    chk("rst_ring_ch", 32'(ring_ch), 0);
    chk("rst_timeout", 32'(timeout_p), 0);
    chk("rst_set_err", 32'(set_err), 0);
    rst = 1'b0;
    step(1);

    // ch0 at 7:30: one cycle of latency after the match minute appears
    cfg(0, 7, 30, 1'b1);
    chk("cfg_ok_no_err", 32'(set_err), 0);
    nowM = 6'd30;
    chk("fire_latency_pre", 32'(ringing), 0);
    step(1);
    chk("fire_ringing", 32'(ringing), 32'h1);
    chk("fire_ring_ch", 32'(ring_ch), 0);
    chk("fire_any", 32'(any_ring), 1);

    // ACK while match persists: no re-fire this minute, fires again next day
    cmd(0, 1'b0);
    chk("ack_drop", 32'(ringing), 0);
    chk("ack_any", 32'(any_ring), 0);
    step(100);
    chk("ack_no_refire", 32'(ringing), 0);
    at(8, 0, 1);
    at(7, 29, 1);
    at(7, 30, 1);
    chk("next_day_fire", 32'(ringing), 32'h1);
    cmd(0, 1'b0);

    // ch1 snooze across midnight, then the fourth snooze acts as ACK
    cfg(1, 23, 58, 1'b1);
    at(23, 57, 1);
    at(23, 58, 1);
    chk("ch1_fire", 32'(ringing), 32'h2);
    chk("ch1_ring_ch", 32'(ring_ch), 1);
    cmd(1, 1'b1);
    chk("snz1_quiet", 32'(ringing), 0);
    at(0, 2, 2);
    chk("snz1_not_yet", 32'(ringing), 0);
    at(0, 3, 1);
    chk("snz1_wrap_fire", 32'(ringing), 32'h2);
    cmd(1, 1'b1);
    at(0, 8, 1);
    chk("snz2_fire", 32'(ringing), 32'h2);
    cmd(1, 1'b1);
    at(0, 13, 1);
    chk("snz3_fire", 32'(ringing), 32'h2);
    cmd(1, 1'b1);
    chk("snz4_as_ack", 32'(ringing), 0);
    at(0, 18, 2);
    chk("snz4_armed_no_fire", 32'(ringing), 0);

    // ch2 auto-timeout after two minute boundaries
    cfg(2, 12, 0, 1'b1);
    at(11, 59, 1);
    at(12, 0, 1);
    chk("ch2_fire", 32'(ringing), 32'h4);
    at(12, 1, 1);
    chk("ch2_still", 32'(ringing), 32'h4);
    chk("ch2_no_to_yet", 32'(timeout_p), 0);
    at(12, 2, 1);
    chk("ch2_timeout", 32'(timeout_p), 32'h4);
    chk("ch2_drop", 32'(ringing), 0);
    step(1);
    chk("ch2_to_single", 32'(timeout_p), 0);

    // ch1 and ch3 both at 6:00: lowest index reported
    cfg(1, 6, 0, 1'b1);
    cfg(3, 6, 0, 1'b1);
    at(5, 59, 1);
    at(6, 0, 1);
    chk("dual_ringing", 32'(ringing), 32'ha);
    chk("dual_ring_ch", 32'(ring_ch), 1);
    cmd(1, 1'b0);
    chk("dual_after_ack", 32'(ringing), 32'h8);
    chk("dual_ring_ch3", 32'(ring_ch), 3);
    cmd(3, 1'b0);
    chk("dual_clear", 32'(ring_ch), 0);

    // rejected configs leave ch0 at 7:30
    cfg(0, 24, 0, 1'b1);
    chk("bad_hour_err", 32'(set_err), 1);
    step(1);
    chk("err_single", 32'(set_err), 0);
    cfg(0, 7, 60, 1'b0);
    chk("bad_min_err", 32'(set_err), 1);
    at(7, 29, 1);
    at(7, 30, 1);
    chk("cfg_unchanged", 32'(ringing), 32'h1);

    // set and ACK together: set wins, new target armed
    set_we = 1'b1; set_ch = 2'd0; set_h = 5'd8; set_m = 6'd0; set_en = 1'b1;
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_op = 1'b0;
    step(1);
    set_we = 1'b0; cmd_valid = 1'b0;
    chk("set_ack_drop", 32'(ringing), 0);
    chk("set_ack_no_err", 32'(set_err), 0);
    at(7, 59, 1);
    at(8, 0, 1);
    chk("new_target_fire", 32'(ringing), 32'h1);

    // reset mid-ring
    rst = 1'b1;
    step(1);
    chk("rst_mid_ring", 32'(ringing), 0);
    chk("rst_mid_any", 32'(any_ring), 0);
    rst = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
